// File: rtl/setting_sweep_ctrl_pkg.sv
// rtl/setting_sweep_ctrl_pkg.sv - shared types and defaults for the setting sweep controller
// Contents: sweep FSM state enum, error-count format, default sweep ranges.
package setting_sweep_ctrl_pkg;

    // Widths of the link emulator's CTLE (rx) and FFE (tx) setting buses.
    localparam int RX_SETTING_WIDTH = 4;
    localparam int TX_SETTING_WIDTH = 4;

    localparam int SWEEP_ERR_W  = 32;

    // By default every code of each setting bus is swept.
    localparam int SWEEP_RX_MAX = (1 << RX_SETTING_WIDTH) - 1;
    localparam int SWEEP_TX_MAX = (1 << TX_SETTING_WIDTH) - 1;

    typedef logic [SWEEP_ERR_W-1:0] err_format_t;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        CAPTURE,
        NEXT,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/sweep_best_tracker.sv
// rtl/sweep_best_tracker.sv - keeps the lowest-error (tx, rx) point seen in the current sweep
// Ports: clk, rst (sync active-high), clear (sweep start), capture (one point completed),
//        point_rx/point_tx/point_err (completed point), best_rx/best_tx/best_err (best so far).
module sweep_best_tracker
    import setting_sweep_ctrl_pkg::*;
#(
    parameter int RX_W  = RX_SETTING_WIDTH,
    parameter int TX_W  = TX_SETTING_WIDTH,
    parameter int ERR_W = SWEEP_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             capture,
    input  logic [RX_W-1:0]  point_rx,
    input  logic [TX_W-1:0]  point_tx,
    input  logic [ERR_W-1:0] point_err,
    output logic [RX_W-1:0]  best_rx,
    output logic [TX_W-1:0]  best_tx,
    output logic [ERR_W-1:0] best_err
);

    // Strict less-than: on a tie the earlier point in sweep order is kept.
    // best_err starts at all-ones, so an all-ones point never displaces (0,0).
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_rx  <= '0;
            best_tx  <= '0;
            best_err <= '1;
        end else if (capture && (point_err < best_err)) begin
            best_rx  <= point_rx;
            best_tx  <= point_tx;
            best_err <= point_err;
        end
    end

endmodule

// File: rtl/setting_sweep_ctrl.sv
// rtl/setting_sweep_ctrl.sv - sweeps every (tx_setting, rx_setting) pair of the link emulator
// Ports: clk, rst (sync active-high), start (level), sim_done/err_count (from emulator);
//        emu_rst/rx_setting/tx_setting (to emulator); busy, sweep_done;
//        result_valid/result_rx/result_tx/result_err (one pulse per point);
//        best_rx/best_tx/best_err (lowest error so far).
// Optional: define SWEEP_TIMEOUT_EN to add a RUN watchdog (TIMEOUT_CYCLES) and timeout_seen.
module setting_sweep_ctrl
    import setting_sweep_ctrl_pkg::*;
#(
    parameter int RX_W          = RX_SETTING_WIDTH,
    parameter int TX_W          = TX_SETTING_WIDTH,
    parameter int RX_MAX        = SWEEP_RX_MAX,
    parameter int TX_MAX        = SWEEP_TX_MAX,
    parameter int ERR_W         = SWEEP_ERR_W,
    parameter int SETTLE_CYCLES = 16
`ifdef SWEEP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2**24
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sim_done,
    input  logic [ERR_W-1:0] err_count,
    output logic             emu_rst,
    output logic [RX_W-1:0]  rx_setting,
    output logic [TX_W-1:0]  tx_setting,
    output logic             busy,
    output logic             result_valid,
    output logic [RX_W-1:0]  result_rx,
    output logic [TX_W-1:0]  result_tx,
    output logic [ERR_W-1:0] result_err,
    output logic [RX_W-1:0]  best_rx,
    output logic [TX_W-1:0]  best_tx,
    output logic [ERR_W-1:0] best_err,
    output logic             sweep_done
`ifdef SWEEP_TIMEOUT_EN
    ,
    output logic             timeout_seen
`endif
);

    localparam int                SETTLE_W    = $clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [RX_W-1:0]   RX_LAST     = RX_W'(RX_MAX);
    localparam logic [TX_W-1:0]   TX_LAST     = TX_W'(TX_MAX);

    sweep_state_t          state;
    sweep_state_t          state_nxt;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic                  run_armed;    // low only during the first RUN cycle
    logic                  done_seen;
    logic                  sweep_start;

    assign done_seen   = run_armed && sim_done;
    assign sweep_start = (state == IDLE) && start;

`ifdef SWEEP_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;

    assign wd_expired = (wd_cnt == WD_LAST);

    // The counter idles at zero outside RUN, so it is clear on every RUN entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt       <= '0;
            timeout_seen <= 1'b0;
        end else begin
            wd_cnt <= (state == RUN) ? wd_cnt + 1'b1 : '0;
            if (sweep_start) begin
                timeout_seen <= 1'b0;
            end else if ((state == RUN) && !done_seen && wd_expired) begin
                timeout_seen <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt    = state;
        emu_rst      = 1'b1;
        busy         = 1'b1;
        result_valid = 1'b0;
        sweep_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = RESET;
            end
            RESET: begin
                if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
            end
            RUN: begin
                emu_rst = 1'b0;
                if (done_seen) state_nxt = CAPTURE;
`ifdef SWEEP_TIMEOUT_EN
                else if (wd_expired) state_nxt = CAPTURE;
`endif
            end
            CAPTURE: begin
                result_valid = 1'b1;
                state_nxt    = NEXT;
            end
            NEXT: begin
                if ((rx_setting < RX_LAST) || (tx_setting < TX_LAST)) state_nxt = RESET;
                else                                                  state_nxt = DONE;
            end
            DONE: begin
                busy       = 1'b0;
                sweep_done = 1'b1;
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            run_armed  <= 1'b0;
            rx_setting <= '0;
            tx_setting <= '0;
            result_rx  <= '0;
            result_tx  <= '0;
            result_err <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        rx_setting <= '0;
                        tx_setting <= '0;
                        settle_cnt <= '0;
                    end
                end
                RESET: begin
                    run_armed  <= 1'b0;
                    settle_cnt <= (state_nxt == RUN) ? '0 : settle_cnt + 1'b1;
                end
                RUN: begin
                    run_armed <= 1'b1;
                    if (state_nxt == CAPTURE) begin
                        result_rx <= rx_setting;
                        result_tx <= tx_setting;
`ifdef SWEEP_TIMEOUT_EN
                        result_err <= done_seen ? err_count : '1;
`else
                        result_err <= err_count;
`endif
                    end
                end
                NEXT: begin
                    // tx is the outer loop, rx the inner one.
                    if (rx_setting < RX_LAST) begin
                        rx_setting <= rx_setting + 1'b1;
                    end else if (tx_setting < TX_LAST) begin
                        rx_setting <= '0;
                        tx_setting <= tx_setting + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sweep_best_tracker #(
        .RX_W  (RX_W),
        .TX_W  (TX_W),
        .ERR_W (ERR_W)
    ) u_best (
        .clk       (clk),
        .rst       (rst),
        .clear     (sweep_start),
        .capture   (result_valid),
        .point_rx  (result_rx),
        .point_tx  (result_tx),
        .point_err (result_err),
        .best_rx   (best_rx),
        .best_tx   (best_tx),
        .best_err  (best_err)
    );

endmodule

// File: tb/tb_setting_sweep_ctrl.sv
// tb/tb_setting_sweep_ctrl.sv - scoreboard bench for setting_sweep_ctrl with an emulator model
module tb_setting_sweep_ctrl;

    localparam int RX_W    = 4;
    localparam int TX_W    = 4;
    localparam int RX_MAX  = 1;
    localparam int TX_MAX  = 1;
    localparam int ERR_W   = 32;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;
    localparam int NPTS    = (RX_MAX + 1) * (TX_MAX + 1);
    localparam logic [ERR_W-1:0] ALL1 = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sim_done;
    logic [ERR_W-1:0] err_count;
    logic             emu_rst;
    logic [RX_W-1:0]  rx_setting;
    logic [TX_W-1:0]  tx_setting;
    logic             busy;
    logic             result_valid;
    logic [RX_W-1:0]  result_rx;
    logic [TX_W-1:0]  result_tx;
    logic [ERR_W-1:0] result_err;
    logic [RX_W-1:0]  best_rx;
    logic [TX_W-1:0]  best_tx;
    logic [ERR_W-1:0] best_err;
    logic             sweep_done;
`ifdef SWEEP_TIMEOUT_EN
    logic             timeout_seen;
`endif

    always #5 clk = ~clk;

    setting_sweep_ctrl #(
        .RX_W          (RX_W),
        .TX_W          (TX_W),
        .RX_MAX        (RX_MAX),
        .TX_MAX        (TX_MAX),
        .ERR_W         (ERR_W),
        .SETTLE_CYCLES (SETTLE)
`ifdef SWEEP_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TIMEOUT)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sim_done     (sim_done),
        .err_count    (err_count),
        .emu_rst      (emu_rst),
        .rx_setting   (rx_setting),
        .tx_setting   (tx_setting),
        .busy         (busy),
        .result_valid (result_valid),
        .result_rx    (result_rx),
        .result_tx    (result_tx),
        .result_err   (result_err),
        .best_rx      (best_rx),
        .best_tx      (best_tx),
        .best_err     (best_err),
        .sweep_done   (sweep_done)
`ifdef SWEEP_TIMEOUT_EN
        ,
        .timeout_seen (timeout_seen)
`endif
    );

    typedef struct {
        int               tx;
        int               rx;
        logic [ERR_W-1:0] err;
    } point_t;

    point_t           exp_q[$];
    logic [ERR_W-1:0] err_list[$];
    int               run_len_q[$];
    logic [ERR_W-1:0] fixed_vals[NPTS];

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt;

    int emu_delay;
    bit emu_stuck;
    bit emu_never;
    bit emu_abort;
    bit mon_flush;

    logic [ERR_W-1:0] m_best_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Emulator: after emu_rst falls, waits d cycles then raises sim_done with the next
    // queued error count; drops it when emu_rst rises. Pushes the expected RUN length:
    // sim_done seen in the first RUN cycle is ignored, so the length is max(d,1)+1.
    initial begin
        bit               prev;
        bit               active;
        int               cnt;
        int               d;
        logic [ERR_W-1:0] val;
        prev      = 1'b1;
        active    = 1'b0;
        cnt       = 0;
        val       = '0;
        sim_done  = 1'b0;
        err_count = '0;
        forever begin
            @(negedge clk);
            if (emu_abort) begin
                active   = 1'b0;
                sim_done = 1'b0;
                if (emu_rst === 1'b1) begin
                    emu_abort = 1'b0;
                    prev      = 1'b1;
                end
                continue;
            end
            if (prev && (emu_rst === 1'b0)) begin
                if (err_list.size() > 0) val = err_list.pop_front();
                else                     val = '0;
                if (emu_stuck)           d = 0;
                else if (emu_delay >= 0) d = emu_delay;
                else                     d = $urandom_range(0, 8);
                active = !emu_never;
                cnt    = d;
                run_len_q.push_back(emu_never ? TIMEOUT : ((d < 1) ? 1 : d) + 1);
            end
            if (active && (emu_rst === 1'b0)) begin
                if (cnt == 0) begin
                    sim_done  = 1'b1;
                    err_count = val;
                    active    = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (emu_rst === 1'b1) begin
                sim_done  = emu_stuck;
                err_count = emu_stuck ? 32'h5A5A_5A5A : ERR_W'($urandom);
            end
            prev = (emu_rst === 1'b1);
        end
    end

    // Monitor: pops the scoreboard on every result_valid, checks emu_rst high-window
    // length before each RUN (RESET only for the first point, CAPTURE+NEXT+RESET after),
    // setting stability while emu_rst=0, and RUN length against the emulator's expectation.
    initial begin
        bit               syncing;
        bit               prev_rst;
        bit               first_pt;
        bit               moved;
        bit               fall;
        bit               rise;
        int               hi_cnt;
        int               lo_cnt;
        logic [RX_W-1:0]  w_rx;
        logic [TX_W-1:0]  w_tx;
        point_t           p;
        syncing  = 1'b1;
        prev_rst = 1'b1;
        first_pt = 1'b1;
        moved    = 1'b0;
        hi_cnt   = 0;
        lo_cnt   = 0;
        w_rx     = '0;
        w_tx     = '0;
        forever begin
            @(negedge clk);
            if (mon_flush) begin
                mon_flush = 1'b0;
                syncing   = 1'b1;
            end
            if (syncing) begin
                if ((emu_rst === 1'b1) && (busy === 1'b0)) begin
                    syncing  = 1'b0;
                    prev_rst = 1'b1;
                    first_pt = 1'b1;
                    hi_cnt   = 0;
                end
                continue;
            end
            fall = prev_rst && (emu_rst === 1'b0);
            rise = !prev_rst && (emu_rst === 1'b1);
            if (rise) begin
                check("settings stable while emu_rst=0", moved, 0);
                if (run_len_q.size() == 0) check("run length expectation present", 0, 1);
                else                       check("run length", lo_cnt, run_len_q.pop_front());
                hi_cnt = 0;
            end
            if (busy !== 1'b1) begin
                first_pt = 1'b1;
                hi_cnt   = 0;
            end
            if ((busy === 1'b1) && (emu_rst === 1'b1)) hi_cnt++;
            if (fall) begin
                check("emu_rst high cycles before run", hi_cnt, first_pt ? SETTLE : SETTLE + 2);
                first_pt = 1'b0;
                hi_cnt   = 0;
                lo_cnt   = 0;
                moved    = 1'b0;
                w_rx     = rx_setting;
                w_tx     = tx_setting;
            end
            if (emu_rst === 1'b0) begin
                lo_cnt++;
                if ((rx_setting !== w_rx) || (tx_setting !== w_tx)) moved = 1'b1;
            end
            if (result_valid === 1'b1) begin
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    check("result_valid with empty scoreboard", result_valid, 0);
                end else begin
                    p = exp_q.pop_front();
                    check("result_tx", result_tx, p.tx);
                    check("result_rx", result_rx, p.rx);
                    check("result_err", result_err, p.err);
                end
            end
            prev_rst = (emu_rst === 1'b1);
        end
    end

    // Queues the expected points in tx-outer/rx-inner order, computes the expected best
    // point (first strictly lowest error), runs the sweep and checks the outcome.
    task automatic run_sweep(input int delay, input bit stuck, input bit never, input bit use_fixed);
        logic [ERR_W-1:0] e;
        logic [ERR_W-1:0] bb;
        int               brx;
        int               btx;
        int               idx;
        int               cyc;
        emu_delay = delay;
        emu_stuck = stuck;
        emu_never = never;
        bb        = ALL1;
        brx       = 0;
        btx       = 0;
        idx       = 0;
        for (int tx = 0; tx <= TX_MAX; tx++) begin
            for (int rx = 0; rx <= RX_MAX; rx++) begin
                if (use_fixed)                      e = fixed_vals[idx];
                else if ($urandom_range(0, 3) == 0) e = ERR_W'($urandom);
                else                                e = ERR_W'($urandom_range(0, 4));
                err_list.push_back(e);
                if (never) e = ALL1;
                exp_q.push_back('{tx: tx, rx: rx, err: e});
                if (e < bb) begin
                    bb  = e;
                    brx = rx;
                    btx = tx;
                end
                idx++;
            end
        end
        m_best_err = bb;
        pulse_cnt  = 0;
        start      = 1'b1;
        cyc        = 0;
        while ((sweep_done !== 1'b1) && (cyc < 5000)) begin
            @(negedge clk);
            cyc++;
        end
        check("sweep_done reached", sweep_done, 1);
        check("result_valid pulse count", pulse_cnt, NPTS);
        check("scoreboard drained", exp_q.size(), 0);
        check("best_tx", best_tx, btx);
        check("best_rx", best_rx, brx);
        check("best_err", best_err, bb);
    endtask

    task automatic finish_sweep();
        start = 1'b0;
        @(negedge clk);
        check("back to idle after start drop", {sweep_done, busy, emu_rst}, 3'b001);
    endtask

    initial begin
        bit held;
        int cyc;
        rst       = 1'b1;
        start     = 1'b0;
        emu_delay = 10;
        emu_stuck = 1'b0;
        emu_never = 1'b0;
        emu_abort = 1'b0;
        mon_flush = 1'b0;
        pulse_cnt = 0;
        repeat (3) @(negedge clk);

        check("reset emu_rst", emu_rst, 1);
        check("reset busy", busy, 0);
        check("reset result_valid", result_valid, 0);
        check("reset sweep_done", sweep_done, 0);
        check("reset settings", {tx_setting, rx_setting}, 0);
        check("reset result fields", {result_tx, result_rx, result_err}, 0);
        check("reset best settings", {best_tx, best_rx}, 0);
        check("reset best_err", best_err, ALL1);
`ifdef SWEEP_TIMEOUT_EN
        check("reset timeout_seen", timeout_seen, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed sweep: 7,3,3,9 with sim_done 10 cycles after emu_rst falls.
        fixed_vals = '{32'd7, 32'd3, 32'd3, 32'd9};
        run_sweep(10, 1'b0, 1'b0, 1'b1);
        held = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if ((sweep_done !== 1'b1) || (busy !== 1'b0)) held = 1'b0;
        end
        check("DONE held while start high", held, 1);
        finish_sweep();
        check("best_err held after done", best_err, m_best_err);

        // sim_done stuck high through reset: capture must land in the second RUN cycle.
        run_sweep(0, 1'b1, 1'b0, 1'b0);
        finish_sweep();

        repeat (3) begin
            run_sweep(-1, 1'b0, 1'b0, 1'b0);
            finish_sweep();
        end

        // Every point all-ones: no strict improvement, best stays at (0,0).
        fixed_vals = '{ALL1, ALL1, ALL1, ALL1};
        run_sweep(1, 1'b0, 1'b0, 1'b1);
        finish_sweep();

        // Abort with rst in the RUN phase of the third point.
        emu_delay = 30;
        emu_stuck = 1'b0;
        emu_never = 1'b0;
        for (int i = 0; i < NPTS; i++) begin
            logic [ERR_W-1:0] e;
            e = ERR_W'($urandom_range(1, 9));
            err_list.push_back(e);
            exp_q.push_back('{tx: i / (RX_MAX + 1), rx: i % (RX_MAX + 1), err: e});
        end
        pulse_cnt = 0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while ((pulse_cnt < 2) && (cyc < 2000)) begin
            @(negedge clk);
            cyc++;
        end
        check("two points before abort", pulse_cnt, 2);
        cyc = 0;
        while ((emu_rst !== 1'b0) && (cyc < 200)) begin
            @(negedge clk);
            cyc++;
        end
        check("third point reached RUN", emu_rst, 0);
        repeat (3) @(negedge clk);
        check("best updated before abort", best_err != ALL1, 1);
        rst       = 1'b1;
        mon_flush = 1'b1;
        emu_abort = 1'b1;
        @(negedge clk);
        check("abort emu_rst", emu_rst, 1);
        check("abort busy", busy, 0);
        check("abort result_valid", result_valid, 0);
        check("abort sweep_done", sweep_done, 0);
        check("abort best_err", best_err, ALL1);
        check("abort settings", {tx_setting, rx_setting}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no pulse after abort", pulse_cnt, 2);
        exp_q.delete();
        err_list.delete();
        run_len_q.delete();

        // Re-sweep after abort starts again from (0,0).
        run_sweep(-1, 1'b0, 1'b0, 1'b0);
        finish_sweep();

`ifdef SWEEP_TIMEOUT_EN
        run_sweep(0, 1'b0, 1'b1, 1'b0);
        check("timeout_seen after watchdog", timeout_seen, 1);
        finish_sweep();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
